// File: rtl/lsu.sv
// lsu: load/store unit driving a word-addressed, word-wide data memory.
// Sub-word stores are done as read-merge-write, because the memory only has a
// whole-word write enable. Load data is extended and returned on a one-cycle strobe.
module lsu #(
    parameter int unsigned DEPTH_LOG2 = 9
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] mem_addr,
    output logic        mem_we,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_MERGE = 3'd2;
    localparam logic [2:0] S_WRITE = 3'd3;
    localparam logic [2:0] S_RESP  = 3'd4;

    logic [2:0]  state_q,      state_d;
    logic [1:0]  off_q,        off_d;
    logic [2:0]  funct3_q,     funct3_d;
    logic [15:0] wdata_q,      wdata_d;
    logic [31:0] mem_addr_q,   mem_addr_d;
    logic [31:0] mem_wdata_q,  mem_wdata_d;
    logic [31:0] resp_rdata_q, resp_rdata_d;
    logic        resp_err_q,   resp_err_d;

    logic        req_err;
    logic        bad_funct3;
    logic        misaligned;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] load_ext;
    logic [31:0] merged;

    // Address bits above the memory depth alias away; keep them visibly consumed.
    logic unused_addr_hi;
    assign unused_addr_hi = ^req_addr[31:DEPTH_LOG2+2];

    // Classify the incoming request: illegal width/sign code or misaligned address.
    always_comb begin
        bad_funct3 = (req_funct3[1:0] == 2'b11)
                  || (req_funct3 == 3'b110)
                  || (req_we && req_funct3[2]);
        misaligned = ((req_funct3[1:0] == 2'b01) && req_addr[0])
                  || ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
        req_err    = bad_funct3 || misaligned;
    end

    // Pick the addressed lane out of the read word and sign/zero extend it.
    always_comb begin
        case (off_q)
            2'd0:    byte_sel = mem_rdata[7:0];
            2'd1:    byte_sel = mem_rdata[15:8];
            2'd2:    byte_sel = mem_rdata[23:16];
            default: byte_sel = mem_rdata[31:24];
        endcase
        half_sel = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (funct3_q[1:0])
            2'b00:   load_ext = funct3_q[2] ? {24'd0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
            2'b01:   load_ext = funct3_q[2] ? {16'd0, half_sel} : {{16{half_sel[15]}}, half_sel};
            default: load_ext = mem_rdata;
        endcase
    end

    // Overlay the store byte/half onto the word read back during MERGE.
    always_comb begin
        merged = mem_rdata;
        if (funct3_q[1:0] == 2'b00) begin
            case (off_q)
                2'd0:    merged[7:0]   = wdata_q[7:0];
                2'd1:    merged[15:8]  = wdata_q[7:0];
                2'd2:    merged[23:16] = wdata_q[7:0];
                default: merged[31:24] = wdata_q[7:0];
            endcase
        end else if (off_q[1]) begin
            merged[31:16] = wdata_q;
        end else begin
            merged[15:0] = wdata_q;
        end
    end

    // Sequencing of one access: latch on accept, then LOAD / MERGE+WRITE / WRITE, then RESP.
    always_comb begin
        state_d      = state_q;
        off_d        = off_q;
        funct3_d     = funct3_q;
        wdata_d      = wdata_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        resp_rdata_d = resp_rdata_q;
        resp_err_d   = resp_err_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    off_d        = req_addr[1:0];
                    funct3_d     = req_funct3;
                    wdata_d      = req_wdata[15:0];
                    mem_addr_d   = {{(32-DEPTH_LOG2){1'b0}}, req_addr[DEPTH_LOG2+1:2]};
                    resp_rdata_d = '0;
                    resp_err_d   = req_err;
                    if (req_err) begin
                        state_d = S_RESP;
                    end else if (!req_we) begin
                        state_d = S_LOAD;
                    end else if (req_funct3[1:0] == 2'b10) begin
                        mem_wdata_d = req_wdata;
                        state_d     = S_WRITE;
                    end else begin
                        state_d = S_MERGE;
                    end
                end
            end
            S_LOAD: begin
                resp_rdata_d = load_ext;
                state_d      = S_RESP;
            end
            S_MERGE: begin
                mem_wdata_d = merged;
                state_d     = S_WRITE;
            end
            S_WRITE: state_d = S_RESP;
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // State registers; reset drops any in-flight access immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            off_q        <= '0;
            funct3_q     <= '0;
            wdata_q      <= '0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            off_q        <= off_d;
            funct3_q     <= funct3_d;
            wdata_q      <= wdata_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
        end
    end

    assign req_ready  = (state_q == S_IDLE);
    assign resp_valid = (state_q == S_RESP);
    assign mem_we     = (state_q == S_WRITE);
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;

endmodule
